// File: rtl/debounce_pkg.sv
// Shared types and default cycle counts for the push-button debouncer (10 MHz clock).
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_CHK,
        S_HIGH,
        S_FALL_CHK
    } db_state_t;

    localparam int DEF_STABLE_CYCLES = 100_000;    // 10 ms
    localparam int DEF_REPEAT_DELAY  = 5_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 1_000_000;  // 100 ms

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/module_sync2.sv
// Two-flop synchronizer with synchronous reset, one independent chain per bit
// so that it can be shared by all asynchronous switch inputs.
module module_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic r_meta;
        logic r_sync;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= i_async[gi];
                r_sync <= r_meta;
            end
        end

        assign o_sync[gi] = r_sync;
    end

endmodule

// File: rtl/module_debounce_ce.sv
// Debounces one raw push-button into a registered single-cycle clock enable plus a clean level.
// Define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module module_debounce_ce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic ce_o,
    output logic btn_db_o
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("module_debounce_ce: STABLE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("module_debounce_ce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic             w_btn_s;
    db_state_t        r_state;
    db_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_ce;
    logic             w_ce_next;
    logic             r_db;
    logic             w_db_next;
    logic             w_rep_fire;

    module_sync2 #(
        .WIDTH (1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (btn_i),
        .o_sync  (w_btn_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_ce    <= 1'b0;
            r_db    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ce    <= w_ce_next;
            r_db    <= w_db_next;
        end
    end

    // Any sample that disagrees with the level under test restarts qualification.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_LOW: begin
                if (w_btn_s) begin
                    w_state_next = S_RISE_CHK;
                    w_cnt_next   = CNT_W'(1);
                end else begin
                    w_cnt_next   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!w_btn_s) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!w_btn_s) begin
                    w_state_next = S_FALL_CHK;
                    w_cnt_next   = CNT_W'(1);
                end else begin
                    w_cnt_next   = '0;
                end
            end
            S_FALL_CHK: begin
                if (w_btn_s) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_db_next = r_db;
        w_ce_next = 1'b0;
        if (r_state == S_RISE_CHK && w_state_next == S_HIGH) begin
            w_db_next = 1'b1;
            w_ce_next = 1'b1;
        end
        if (r_state == S_FALL_CHK && w_state_next == S_LOW) begin
            w_db_next = 1'b0;
        end
        if (w_rep_fire) begin
            w_ce_next = 1'b1;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;
    logic [REP_W-1:0] w_rep_target;

    // First repeat waits the long delay, later ones use the shorter period.
    assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
    assign w_rep_fire   = (r_state == S_HIGH) && (w_state_next == S_HIGH) &&
                          (r_rep_cnt == w_rep_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state != S_HIGH || w_state_next != S_HIGH) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign ce_o     = r_ce;
    assign btn_db_o = r_db;

endmodule

// File: tb/tb_module_debounce_ce.sv
// Directed bench for module_debounce_ce with short sim timing (STABLE=8, DELAY=20, PERIOD=5).
// Expected pulses follow the 2-flop + STABLE_CYCLES acceptance latency, counted in edges after a btn change.
`timescale 1ns/1ps
module tb_module_debounce_ce;

    localparam int STABLE = 8;
    localparam int RD     = 20;
    localparam int RP     = 5;
    localparam int LAT    = 2 + STABLE;

    logic clk = 1'b0;
    logic rst;
    logic btn_i;
    logic ce_o;
    logic btn_db_o;

    int n_checks = 0;
    int n_errors = 0;

    module_debounce_ce #(
        .STABLE_CYCLES (STABLE),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .ce_o     (ce_o),
        .btn_db_o (btn_db_o)
    );

    always #50 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge, then sample 1 ns later; inputs are also changed at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected ce for d edges after acceptance while the button stays held.
    function automatic logic rep_hit(input int d);
        if (d == 0) return 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (d >= RD && ((d - RD) % RP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Hold btn high n edges from now, expecting acceptance LAT edges after the change.
    task automatic hold_high(input string tag, input int n);
        btn_i = 1'b1;
        for (int e = 1; e <= n; e++) begin
            step();
            check_value($sformatf("%s ce e%0d", tag, e), ce_o, (e >= LAT) ? rep_hit(e - LAT) : 1'b0);
            check_value($sformatf("%s db e%0d", tag, e), btn_db_o, (e >= LAT) ? 1'b1 : 1'b0);
        end
    endtask

    // Release from S_HIGH held for hold_d edges since acceptance; the first two edges still see 1.
    task automatic release_phase(input string tag, input int hold_d);
        btn_i = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            check_value($sformatf("%s ce e%0d", tag, k), ce_o, (k <= 2) ? rep_hit(hold_d + k) : 1'b0);
            check_value($sformatf("%s db e%0d", tag, k), btn_db_o, (k < LAT) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        btn_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("reset ce", ce_o, 1'b0);
            check_value("reset db", btn_db_o, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        $display("reset: outputs low during reset");

        // 1: clean press held 30 edges
        hold_high("t1", 30);
        $display("t1 clean press: accept at edge %0d", LAT);

        // 4: release after 20 edges in S_HIGH
        release_phase("t4", 30 - LAT);
        $display("t4 release: level falls at edge %0d, no ce", LAT);

        // 2: bounce, toggling every 3 cycles for 15 cycles, last toggle before edge 13
        for (int k = 0; k < 40; k++) begin
            int e;
            btn_i = (k < 15) ? (((k / 3) % 2) == 0) : 1'b1;
            step();
            e = k + 1;
            check_value($sformatf("t2 ce e%0d", e), ce_o, (e >= 13 + LAT - 1) ? rep_hit(e - (13 + LAT - 1)) : 1'b0);
            check_value($sformatf("t2 db e%0d", e), btn_db_o, (e >= 13 + LAT - 1) ? 1'b1 : 1'b0);
        end
        $display("t2 bounce: single accept at edge %0d", 13 + LAT - 1);
        release_phase("t2r", 40 - (13 + LAT - 1));

        // 3: glitch of STABLE-1 cycles must be ignored
        for (int k = 0; k < 20; k++) begin
            btn_i = (k < STABLE - 1);
            step();
            check_value($sformatf("t3 ce e%0d", k + 1), ce_o, 1'b0);
            check_value($sformatf("t3 db e%0d", k + 1), btn_db_o, 1'b0);
        end
        $display("t3 glitch: %0d-cycle pulse ignored", STABLE - 1);

        // 3b: exactly STABLE cycles high is accepted, then released before edge 9
        for (int k = 0; k < 20; k++) begin
            int e;
            btn_i = (k < STABLE);
            step();
            e = k + 1;
            check_value($sformatf("t3b ce e%0d", e), ce_o, (e == LAT) ? 1'b1 : 1'b0);
            check_value($sformatf("t3b db e%0d", e), btn_db_o, (e >= LAT && e < STABLE + LAT) ? 1'b1 : 1'b0);
        end
        $display("t3b boundary: %0d-cycle pulse accepted once", STABLE);

        // 5: reset with cnt=5 (after edge 7) while held
        btn_i = 1'b1;
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        step();
        check_value("t5 rst ce", ce_o, 1'b0);
        check_value("t5 rst db", btn_db_o, 1'b0);
        rst = 1'b0;
        hold_high("t5", LAT + 2);
        $display("t5 reset mid-check: re-qualified, accept %0d edges after reset", LAT);
        release_phase("t5r", 2);

        // 6: hold 39 edges past acceptance (repeats only with the auto-repeat build)
        hold_high("t6", LAT + 39);
        release_phase("t6r", 39);
        $display("t6 long hold: repeat pattern checked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
